// File: rtl/add_seq_64_pkg.sv
// Shared constants for the iterative adder: slice width, FSM encodings and
// the slice-index width helper.
package add_seq_64_pkg;

  localparam int SLICE_W = 16;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  // A single-slice build still needs a one-bit index register.
  function automatic int idx_width(input int nslice);
    return (nslice <= 2) ? 1 : $clog2(nslice);
  endfunction

endpackage

// File: rtl/add_seq_64_cla_16.sv
// 16-bit carry-lookahead adder built from four 4-bit groups. GM_PM=1 resolves
// group carries in one lookahead level; GM_PM=0 ripples between groups.
module cla_16 #(
  parameter bit GM_PM = 1'b0
) (
  input  logic [15:0] A,
  input  logic [15:0] B,
  input  logic        Ci,
  output logic [15:0] S,
  output logic        Co
);

  logic [15:0] g;
  logic [15:0] p;
  logic [15:0] c;
  logic [3:0]  gg;
  logic [3:0]  gp;
  logic [4:0]  gc;

  assign g = A & B;
  assign p = A ^ B;

  always_comb begin
    gg = '0;
    gp = '0;
    for (int k = 0; k < 4; k++) begin
      gg[k] = g[4*k+3]
            | (p[4*k+3] & g[4*k+2])
            | (p[4*k+3] & p[4*k+2] & g[4*k+1])
            | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
      gp[k] = &p[4*k +: 4];
    end
  end

  generate
    if (GM_PM) begin : g_lookahead
      always_comb begin
        logic term;
        gc    = '0;
        gc[0] = Ci;
        for (int j = 0; j < 4; j++) begin
          term = Ci;
          for (int m = 0; m <= j; m++) term = term & gp[m];
          for (int m = 0; m <= j; m++) begin
            logic t;
            t = gg[m];
            for (int n = m + 1; n <= j; n++) t = t & gp[n];
            term = term | t;
          end
          gc[j+1] = term;
        end
      end
    end else begin : g_ripple
      always_comb begin
        gc    = '0;
        gc[0] = Ci;
        for (int j = 0; j < 4; j++) gc[j+1] = gg[j] | (gp[j] & gc[j]);
      end
    end
  endgenerate

  always_comb begin
    c = '0;
    for (int k = 0; k < 4; k++) begin
      c[4*k] = gc[k];
      for (int i = 0; i < 3; i++) c[4*k+i+1] = g[4*k+i] | (p[4*k+i] & c[4*k+i]);
    end
  end

  assign S  = p ^ c;
  assign Co = gc[4];

endmodule

// File: rtl/add_seq_64.sv
// Iterative XLEN-bit add/sub that walks one CLA_16 across XLEN/16 cycles.
// Optional ADD_SEQ_FLAGS_EN adds registered zero/negative/overflow flags.
module add_seq_64
  import add_seq_64_pkg::*;
#(
  parameter  int XLEN   = 64,
  localparam int NSLICE = XLEN / SLICE_W
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_a,
  input  logic [XLEN-1:0] in_b,
  input  logic            in_sub,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_sum,
  output logic            out_co
`ifdef ADD_SEQ_FLAGS_EN
  ,
  output logic            out_zero,
  output logic            out_neg,
  output logic            out_ovf
`endif
);

  localparam int IDX_W = idx_width(NSLICE);

  logic [1:0]         state;
  logic [1:0]         state_nxt;
  logic [IDX_W-1:0]   idx;
  logic               carry;
  logic [XLEN-1:0]    a_reg;
  logic [XLEN-1:0]    b_reg;
  logic [XLEN-1:0]    sum_reg;
  logic [SLICE_W-1:0] sl_a;
  logic [SLICE_W-1:0] sl_b;
  logic [SLICE_W-1:0] sl_s;
  logic               sl_co;
  logic               accept;
  logic               deliver;
  logic               last;

  // in_ready is high exactly while in IDLE, so it doubles as the state gate.
  assign accept  = in_valid & in_ready;
  assign deliver = out_valid & out_ready;
  assign last    = (idx == IDX_W'(NSLICE - 1));

  assign sl_a = a_reg[idx*SLICE_W +: SLICE_W];
  assign sl_b = b_reg[idx*SLICE_W +: SLICE_W];

  cla_16 #(
    .GM_PM (1'b0)
  ) u_cla (
    .A  (sl_a),
    .B  (sl_b),
    .Ci (carry),
    .S  (sl_s),
    .Co (sl_co)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = RUN;
      RUN:     if (last) state_nxt = DONE;
      DONE:    if (deliver) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Control and output stage; the first DONE cycle loads the output register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_co    <= 1'b0;
      idx       <= '0;
      carry     <= 1'b0;
    end else begin
      state    <= state_nxt;
      in_ready <= (state_nxt == IDLE);
      case (state)
        IDLE: begin
          if (accept) begin
            idx   <= '0;
            carry <= in_sub;
          end
        end
        RUN: begin
          carry <= sl_co;
          if (!last) idx <= idx + 1'b1;
        end
        DONE: begin
          if (!out_valid) begin
            out_valid <= 1'b1;
            out_sum   <= sum_reg;
            out_co    <= carry;
          end else if (out_ready) begin
            out_valid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // Operand capture and slice accumulation carry no reset; control gates them.
  always_ff @(posedge clk) begin
    if (accept) begin
      a_reg <= in_a;
      b_reg <= in_sub ? ~in_b : in_b;
    end
    if (state == RUN) sum_reg[idx*SLICE_W +: SLICE_W] <= sl_s;
  end

`ifdef ADD_SEQ_FLAGS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      out_zero <= 1'b0;
      out_neg  <= 1'b0;
      out_ovf  <= 1'b0;
    end else if ((state == DONE) && !out_valid) begin
      out_zero <= (sum_reg == '0);
      out_neg  <= sum_reg[XLEN-1];
      out_ovf  <= (a_reg[XLEN-1] == b_reg[XLEN-1]) && (sum_reg[XLEN-1] != a_reg[XLEN-1]);
    end
  end
`endif

endmodule

// File: tb/tb_add_seq_64.sv
// Table-driven bench for add_seq_64 with a result scoreboard; also covers
// backpressure, ignored inputs and reset mid-operation. Honors ADD_SEQ_FLAGS_EN.
module tb_add_seq_64;

  localparam int XLEN    = 64;
  localparam int NSLICE  = XLEN / 16;
  localparam int LATENCY = NSLICE + 1;

  typedef struct {
    logic [63:0] a;
    logic [63:0] b;
    logic        sub;
    logic [63:0] sum;
    logic        co;
    logic        zero;
    logic        neg;
    logic        ovf;
  } vec_t;

  typedef struct {
    logic [63:0] sum;
    logic        co;
    logic        zero;
    logic        neg;
    logic        ovf;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_a;
  logic [63:0] in_b;
  logic        in_sub;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_sum;
  logic        out_co;
`ifdef ADD_SEQ_FLAGS_EN
  logic        out_zero;
  logic        out_neg;
  logic        out_ovf;
`endif

  int   n_vec  = 0;
  int   n_miss = 0;
  exp_t sb[$];

  add_seq_64 #(.XLEN(XLEN)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_sub    (in_sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_co    (out_co)
`ifdef ADD_SEQ_FLAGS_EN
    ,
    .out_zero  (out_zero),
    .out_neg   (out_neg),
    .out_ovf   (out_ovf)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic exp_t model(input logic [63:0] a, input logic [63:0] b, input logic sub);
    logic [63:0] bb;
    logic [64:0] r;
    exp_t        e;
    bb     = sub ? ~b : b;
    r      = {1'b0, a} + {1'b0, bb} + 65'(sub);
    e.sum  = r[63:0];
    e.co   = r[64];
    e.zero = (r[63:0] == 64'd0);
    e.neg  = r[63];
    e.ovf  = (a[63] == bb[63]) && (r[63] != a[63]);
    return e;
  endfunction

  // Called #1 after a rising edge; leaves time at #1 after the accept edge.
  task automatic issue(input string name, input logic [63:0] a, input logic [63:0] b,
                       input logic s, input exp_t e);
    int g;
    g = 0;
    while (!in_ready && g < 40) begin
      @(posedge clk); #1;
      g++;
    end
    chk({name, "_in_ready"}, 64'(in_ready), 64'd1);
    in_a     = a;
    in_b     = b;
    in_sub   = s;
    in_valid = 1'b1;
    sb.push_back(e);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(input string name, output int lat);
    lat = 0;
    while (!out_valid && lat < 30) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({name, "_latency"}, 64'(lat), 64'(LATENCY));
  endtask

  task automatic compare_result(input string name);
    exp_t e;
    if (sb.size() == 0) begin
      chk({name, "_scoreboard_nonempty"}, 64'd0, 64'd1);
    end else begin
      e = sb.pop_front();
      chk({name, "_sum"}, out_sum, e.sum);
      chk({name, "_co"}, 64'(out_co), 64'(e.co));
`ifdef ADD_SEQ_FLAGS_EN
      chk({name, "_zero"}, 64'(out_zero), 64'(e.zero));
      chk({name, "_neg"}, 64'(out_neg), 64'(e.neg));
      chk({name, "_ovf"}, 64'(out_ovf), 64'(e.ovf));
`endif
    end
  endtask

  task automatic collect(input string name);
    int lat;
    wait_valid(name, lat);
    compare_result(name);
    @(posedge clk); #1;
    chk({name, "_valid_drop"}, 64'(out_valid), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        tbl[10];
    exp_t        e;
    exp_t        ez;
    int          lat;
    logic [63:0] ra;
    logic [63:0] rb;
    logic [63:0] held;
    logic        rs;

    tbl[0] = '{64'h0000_0000_FFFF_FFFF, 64'd1, 1'b0, 64'h0000_0001_0000_0000, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 64'd0, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[2] = '{64'd5, 64'd7, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[3] = '{64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b0, 1'b1, 1'b1};
    tbl[4] = '{64'd7, 64'd5, 1'b1, 64'd2, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[5] = '{64'h8000_0000_0000_0000, 64'd1, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b0, 1'b1};
    tbl[6] = '{64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0, 1'b1, 64'd0, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[7] = '{64'h0000_FFFF_0000_FFFF, 64'h0000_0001_0000_0001, 1'b0, 64'h0001_0000_0001_0000, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[8] = '{64'hFFFF_0000_FFFF_0000, 64'h0001_0000_0001_0000, 1'b0, 64'h0000_0001_0000_0000, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[9] = '{64'd0, 64'd0, 1'b1, 64'd0, 1'b1, 1'b1, 1'b0, 1'b0};

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_sub    = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_in_ready", 64'(in_ready), 64'd1);
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_out_sum", out_sum, 64'd0);
    chk("reset_out_co", 64'(out_co), 64'd0);
`ifdef ADD_SEQ_FLAGS_EN
    chk("reset_flags", {61'd0, out_zero, out_neg, out_ovf}, 64'd0);
`endif
    rst = 1'b0;
    @(posedge clk); #1;

    foreach (tbl[i]) begin
      e = '{tbl[i].sum, tbl[i].co, tbl[i].zero, tbl[i].neg, tbl[i].ovf};
      issue($sformatf("vec%0d", i), tbl[i].a, tbl[i].b, tbl[i].sub, e);
      collect($sformatf("vec%0d", i));
    end

    for (int i = 0; i < 6; i++) begin
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      rs = 1'($urandom_range(0, 1));
      issue($sformatf("rnd%0d", i), ra, rb, rs, model(ra, rb, rs));
      collect($sformatf("rnd%0d", i));
    end

    // Backpressure with input noise during RUN and DONE.
    out_ready = 1'b0;
    issue("bp", 64'h0123_4567_89AB_CDEF, 64'h1111_2222_3333_4444, 1'b0,
          model(64'h0123_4567_89AB_CDEF, 64'h1111_2222_3333_4444, 1'b0));
    lat = 0;
    while (!out_valid && lat < 30) begin
      in_valid = ~in_valid;
      in_a     = {$urandom, $urandom};
      in_b     = {$urandom, $urandom};
      @(posedge clk); #1;
      lat++;
    end
    chk("bp_latency", 64'(lat), 64'(LATENCY));
    held = (sb.size() != 0) ? sb[0].sum : 64'd0;
    compare_result("bp");
    for (int i = 0; i < 10; i++) begin
      in_valid = ~in_valid;
      in_a     = {$urandom, $urandom};
      @(posedge clk); #1;
      chk("bp_hold_sum", out_sum, held);
      chk("bp_hold_in_ready", 64'(in_ready), 64'd0);
      chk("bp_hold_valid", 64'(out_valid), 64'd1);
    end
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("bp_handshake_drop", 64'(out_valid), 64'd0);
    chk("bp_back_to_idle", 64'(in_ready), 64'd1);
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      chk("bp_no_extra_result", 64'(out_valid), 64'd0);
    end

    // Reset while idx==2; the partial result must vanish.
    ez = model(64'hAAAA_AAAA_AAAA_AAAA, 64'h5555_5555_5555_5555, 1'b0);
    issue("mid_rst", 64'hAAAA_AAAA_AAAA_AAAA, 64'h5555_5555_5555_5555, 1'b0, ez);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    void'(sb.pop_back());
    chk("mid_rst_in_ready", 64'(in_ready), 64'd1);
    chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_out_sum", out_sum, 64'd0);
    chk("mid_rst_out_co", 64'(out_co), 64'd0);
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      chk("mid_rst_no_result", 64'(out_valid), 64'd0);
    end
    e = '{64'd7, 1'b0, 1'b0, 1'b0, 1'b0};
    issue("post_rst", 64'd3, 64'd4, 1'b0, e);
    collect("post_rst");

    chk("scoreboard_empty", 64'(sb.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/add_seq_64.md
Name: add_seq_64

Overview:
- Iterative multi-cycle adder/subtractor for XLEN-bit operands.
- Drives a single CLA_16 slice over XLEN/16 cycles:
  - feeds one 16-bit operand slice per cycle;
  - registers the slice sum and carry-out, chaining the carry into the next cycle.
- Sits directly upstream of CLA_16 and consumes its S/Co, so the ALU gets wide add/sub with one 16-bit adder's area.
- valid/ready handshake on both sides.

Parameters:
- XLEN, 64, operand width; must be a multiple of 16 and at least 16.
- NSLICE, XLEN/16, derived slice count; not overridden by users.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  synchronous active-high reset
- in_valid  input  1  operands valid
- in_ready  output  1  block can accept operands
- in_a  input  XLEN  operand A
- in_b  input  XLEN  operand B
- in_sub  input  1  1 = A-B, 0 = A+B
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- out_sum  output  XLEN  A+B or A-B, modulo 2^XLEN
- out_co  output  1  final carry-out; for sub, 1 = no borrow

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Reset values: state=IDLE, in_ready=1, out_valid=0, out_sum=0, out_co=0, slice index=0, carry reg=0.
- FSM states:
  - IDLE: in_ready=1. On in_valid&in_ready:
    - latch a_reg=in_a;
    - latch b_reg = in_sub ? ~in_b : in_b;
    - carry=in_sub; idx=0; go to RUN.
  - RUN: in_ready=0.
    - CLA_16 gets A=a_reg[idx*16+:16], B=b_reg[idx*16+:16], Ci=carry.
    - Each edge: sum_reg[idx*16+:16]<=S, carry<=Co, idx<=idx+1.
    - When idx==NSLICE-1: go to DONE instead of incrementing.
  - DONE: out_valid=1; out_sum=sum_reg; out_co=carry.
    - Outputs stay stable while out_ready=0.
    - On out_ready: go to IDLE; out_valid drops next cycle.
- Latency: out_valid rises exactly NSLICE+1 edges after the accept edge (5 for XLEN=64).
- Throughput: the next accept is no earlier than one cycle after the result handshake. Back-to-back ops are separated by at least NSLICE+2 cycles.
- in_ready is a registered decode of state==IDLE; it has no combinational path from out_ready.
- Operands are captured at accept; input changes during RUN/DONE are ignored.
- in_valid while not in IDLE is ignored, not queued.
- Arithmetic: the full XLEN result wraps modulo 2^XLEN; out_co is the CLA_16 Co of the top slice.
- Simultaneous events:
  - DONE with out_ready=1 and in_valid=1 on the same cycle: the result handshake completes; the input is not accepted (in_ready=0 that cycle).
- rst asserted in any state, including mid-RUN: returns to reset values at the next edge; the partial result is discarded and no out_valid is produced.
- XLEN=16 (NSLICE=1): RUN lasts one cycle; latency is 2.

Optional Feature:
- Macro ADD_SEQ_FLAGS_EN.
- Defined: adds outputs out_zero (1), out_neg (1) and out_ovf (1), all registered and valid with out_valid.
  - out_zero = (out_sum==0).
  - out_neg = out_sum[XLEN-1].
  - out_ovf = signed overflow = (a_reg[XLEN-1]==b_reg[XLEN-1]) & (sum_reg[XLEN-1]!=a_reg[XLEN-1]), using the post-inversion b_reg.
  - All three reset to 0.
- Undefined: the ports do not exist and no flag logic is built.

Decomposition:
- Shared package/include holds:
  - SLICE_W=16;
  - state encodings IDLE=2'd0, RUN=2'd1, DONE=2'd2;
  - the slice-index width function clog2(NSLICE), minimum 1 bit.
- Sub-module: the existing CLA_16, instantiated once with GM_PM=0. No new sub-module is needed.

Test Plan:
- Add, XLEN=64: A=0x0000_0000_FFFF_FFFF, B=1, sub=0 -> out_sum=0x0000_0001_0000_0000, out_co=0, out_valid exactly 5 edges after accept.
- Full carry ripple: A=0xFFFF_FFFF_FFFF_FFFF, B=1, sub=0 -> out_sum=0, out_co=1; with ADD_SEQ_FLAGS_EN, out_zero=1 and out_ovf=0.
- Subtract with borrow: A=5, B=7, sub=1 -> out_sum=0xFFFF_FFFF_FFFF_FFFE, out_co=0; with flags, out_neg=1 and out_ovf=0.
- Signed overflow (flags build): A=0x7FFF_FFFF_FFFF_FFFF, B=1, sub=0 -> out_sum=0x8000_0000_0000_0000, out_ovf=1.
- Backpressure and ignore: hold out_ready=0 for 10 cycles after out_valid, and toggle in_valid/in_a during RUN and DONE -> out_sum stays constant, in_ready stays 0, and exactly one result is delivered when out_ready=1.
- Reset mid-RUN: assert rst for one cycle at idx=2 -> next cycle state IDLE, in_ready=1, out_valid=0, out_sum=0; a following op A=3, B=4 returns 7 with normal latency.
